// File: rtl/peri_bus_arb_if.sv
// Single peripheral-bus channel: request strobes, address and write data one way,
// completion pulse, read data and error flag the other way.
interface peri_bus_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          regw;
    logic          regr;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdat;
    logic          err;

    modport master (
        output regw, regr, adr, wdata,
        input  ack, rdat, err
    );

    modport slave (
        input  regw, regr, adr, wdata,
        output ack, rdat, err
    );
endinterface

// File: rtl/peri_bus_arb.sv
// Two-requester round-robin arbiter for the shared peripheral port, with a
// post-transfer idle gap and a hung-slave timeout.
module peri_bus_arb #(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter int            GAP_CYC   = 1,
    parameter int            TIMEOUT   = 64,
    parameter logic [DW-1:0] ERR_RDATA = DW'(32'hDEADBEEF)
) (
    input  logic           clk,
    input  logic           rstz,
    peri_bus_arb_if.slave  m0,
    peri_bus_arb_if.slave  m1,
    peri_bus_arb_if.master s,
    output logic [1:0]     grant
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_lastGrant;
    logic          r_sRegw;
    logic          r_sRegr;
    logic [AW-1:0] r_sAdr;
    logic [DW-1:0] r_sWdata;
    logic [TW-1:0] r_tmo;
    logic [GW-1:0] r_gapCnt;

    logic          w_req0;
    logic          w_req1;
    logic          w_pick1;
    logic          w_selWrite;
    logic [AW-1:0] w_selAdr;
    logic [DW-1:0] w_selWdata;
    logic          w_inBusy;
    logic          w_slaveDone;
    logic          w_timeout;
    logic          w_ack;
    logic [DW-1:0] w_rdat;

    // r_lastGrant=1 means m1 was served last, so a tie goes to m0.
    always_comb begin
        w_req0     = m0.regw | m0.regr;
        w_req1     = m1.regw | m1.regr;
        w_pick1    = w_req1 & (~w_req0 | ~r_lastGrant);
        w_selWrite = w_pick1 ? m1.regw  : m0.regw;
        w_selAdr   = w_pick1 ? m1.adr   : m0.adr;
        w_selWdata = w_pick1 ? m1.wdata : m0.wdata;
    end

    // A slave ack on the final timeout cycle still counts as a normal completion.
    always_comb begin
        w_inBusy    = (r_state == ST_BUSY);
        w_slaveDone = w_inBusy & s.ack;
        w_timeout   = w_inBusy & ~s.ack & (r_tmo == TW'(TIMEOUT - 1));
        w_ack       = w_slaveDone | w_timeout;
        if (w_timeout) begin
            w_rdat = ERR_RDATA;
        end else if (r_sRegr) begin
            w_rdat = s.rdat;
        end else begin
            w_rdat = '0;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_sRegw     <= 1'b0;
            r_sRegr     <= 1'b0;
            r_sAdr      <= '0;
            r_sWdata    <= '0;
            r_tmo       <= '0;
            r_gapCnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_owner     <= w_pick1;
                        r_lastGrant <= w_pick1;
                        r_sRegw     <= w_selWrite;
                        r_sRegr     <= ~w_selWrite;
                        r_sAdr      <= w_selAdr;
                        r_sWdata    <= w_selWdata;
                        r_tmo       <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_ack) begin
                        r_sRegw  <= 1'b0;
                        r_sRegr  <= 1'b0;
                        r_gapCnt <= '0;
                        r_state  <= ST_GAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gapCnt == GW'(GAP_CYC - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.regw  = r_sRegw;
    assign s.regr  = r_sRegr;
    assign s.adr   = r_sAdr;
    assign s.wdata = r_sWdata;

    assign m0.ack  = w_ack & ~r_owner;
    assign m0.err  = w_timeout & ~r_owner;
    assign m0.rdat = (w_ack & ~r_owner) ? w_rdat : '0;
    assign m1.ack  = w_ack & r_owner;
    assign m1.err  = w_timeout & r_owner;
    assign m1.rdat = (w_ack & r_owner) ? w_rdat : '0;

    assign grant = (r_state == ST_IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_peri_bus_arb.sv
// Bench for peri_bus_arb: directed vector table, round-robin and reset sequences,
// then randomized traffic against a transaction-level reference model.
module tb_peri_bus_arb;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int GAP_CYC = 1;
    localparam int TIMEOUT = 64;
    localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;
    localparam logic [31:0] ADR0 = 32'h00013000;
    localparam logic [31:0] WD0  = 32'h00000041;
    localparam logic [31:0] ADR1 = 32'h00020004;
    localparam logic [31:0] WD1  = 32'h00000099;

    logic       clk = 1'b0;
    logic       rstz = 1'b0;
    logic [1:0] grant;

    peri_bus_arb_if #(.AW(AW), .DW(DW)) m0If ();
    peri_bus_arb_if #(.AW(AW), .DW(DW)) m1If ();
    peri_bus_arb_if #(.AW(AW), .DW(DW)) sIf ();

    peri_bus_arb #(
        .AW(AW), .DW(DW), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT), .ERR_RDATA(ERR_VAL)
    ) dut (
        .clk(clk),
        .rstz(rstz),
        .m0(m0If),
        .m1(m1If),
        .s(sIf),
        .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m0w;
        bit          m0r;
        bit          m1w;
        bit          m1r;
        int          lat;
        logic [31:0] rdat;
        int          expOwner;
        bit          expWrite;
        logic [31:0] expRdat;
        bit          expErr;
        int          expCyc;
    } vec_t;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          slaveCnt = 0;
    int          slaveLat = 3;
    logic [31:0] slaveRdat = '0;
    bit          spuriousEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Peripheral model: acks slaveLat cycles after the strobe rises, once per strobe.
    task automatic slaveStep();
        bit strobe;
        strobe = sIf.regw | sIf.regr;
        if (strobe) slaveCnt++;
        else slaveCnt = 0;
        sIf.ack  = (strobe && slaveCnt == slaveLat + 1) ||
                   (!strobe && spuriousEn && ($urandom_range(0, 4) == 0));
        sIf.rdat = slaveRdat;
    endtask

    task automatic clearMasters();
        m0If.regw = 0; m0If.regr = 0; m0If.adr = '0; m0If.wdata = '0;
        m1If.regw = 0; m1If.regr = 0; m1If.adr = '0; m1If.wdata = '0;
    endtask

    task automatic doReset();
        rstz = 1'b0;
        clearMasters();
        sIf.ack = 0;
        sIf.err = 0;
        slaveCnt = 0;
        repeat (2) @(posedge clk);
        #1 rstz = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int          gotOwner;
        int          gotCyc;
        logic [31:0] gotRdat;
        logic [31:0] otherRdat;
        bit          gotErr;
        bit          dualAck;
        bit          strW;
        bit          strR;
        logic [31:0] strAdr;
        doReset();
        spuriousEn = 1'b0;
        slaveLat   = v.lat;
        slaveRdat  = v.rdat;
        m0If.regw = v.m0w; m0If.regr = v.m0r; m0If.adr = ADR0; m0If.wdata = WD0;
        m1If.regw = v.m1w; m1If.regr = v.m1r; m1If.adr = ADR1; m1If.wdata = WD1;
        gotOwner = -1; gotCyc = -1; gotRdat = '0; otherRdat = '0; gotErr = 0; dualAck = 0;
        strW = 0; strR = 0; strAdr = '0;
        for (int k = 0; k < TIMEOUT + 10; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            slaveStep();
            #1;
            if (k == 1) begin
                strW = sIf.regw; strR = sIf.regr; strAdr = sIf.adr;
            end
            if (m0If.ack && m1If.ack) dualAck = 1;
            if (m0If.ack || m1If.ack) begin
                gotOwner  = m1If.ack ? 1 : 0;
                gotCyc    = k;
                gotRdat   = m1If.ack ? m1If.rdat : m0If.rdat;
                otherRdat = m1If.ack ? m0If.rdat : m1If.rdat;
                gotErr    = m1If.ack ? m1If.err : m0If.err;
                break;
            end
        end
        clearMasters();
        checkOutput($sformatf("vec%0d owner", idx), gotOwner, v.expOwner);
        checkOutput($sformatf("vec%0d ackCycle", idx), gotCyc, v.expCyc);
        checkOutput($sformatf("vec%0d rdat", idx), gotRdat, v.expRdat);
        checkOutput($sformatf("vec%0d err", idx), 32'(gotErr), 32'(v.expErr));
        checkOutput($sformatf("vec%0d s_regw", idx), 32'(strW), 32'(v.expWrite));
        checkOutput($sformatf("vec%0d s_regr", idx), 32'(strR), 32'(!v.expWrite));
        checkOutput($sformatf("vec%0d s_adr", idx), strAdr, (v.expOwner == 1) ? ADR1 : ADR0);
        checkOutput($sformatf("vec%0d dualAck", idx), 32'(dualAck), 32'd0);
        checkOutput($sformatf("vec%0d otherRdat", idx), otherRdat, 32'd0);
    endtask

    task automatic roundRobinSeq();
        int order[6];
        int nAck;
        int cnt0;
        int cnt1;
        int lastAck;
        bit prevStrobe;
        bit strobe;
        doReset();
        spuriousEn = 1'b0;
        slaveLat = 3;
        slaveRdat = 32'h5A5A5A5A;
        nAck = 0; cnt0 = 0; cnt1 = 0; lastAck = -100; prevStrobe = 0;
        for (int i = 0; i < 6; i++) order[i] = -1;
        for (int k = 0; k < 200 && nAck < 6; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            m0If.regw = (cnt0 < 3); m0If.adr = ADR0; m0If.wdata = WD0;
            m1If.regr = (cnt1 < 3); m1If.adr = ADR1;
            slaveStep();
            #1;
            strobe = sIf.regw | sIf.regr;
            if (strobe && !prevStrobe && nAck > 0)
                checkOutput($sformatf("rr strobeGap%0d", nAck), 32'(k - lastAck >= GAP_CYC + 1), 32'd1);
            prevStrobe = strobe;
            if (m0If.ack || m1If.ack) begin
                order[nAck] = m1If.ack ? 1 : 0;
                if (m1If.ack) cnt1++;
                else cnt0++;
                nAck++;
                lastAck = k;
            end
        end
        clearMasters();
        checkOutput("rr ackCount", nAck, 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("rr order%0d", i), order[i], i % 2);
    endtask

    task automatic resetMidTransfer();
        bit m0Acked;
        int m1AckCyc;
        doReset();
        spuriousEn = 1'b0;
        slaveLat = 1000;
        slaveRdat = 32'h76543210;
        m0If.regw = 1; m0If.adr = ADR0; m0If.wdata = WD0;
        m1If.regr = 1; m1If.adr = ADR1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            slaveStep();
            #1;
        end
        checkOutput("rst busyGrant", 32'(grant), 32'd1);
        rstz = 1'b0;
        m0If.regw = 0;
        #1;
        checkOutput("rst grant", 32'(grant), 32'd0);
        checkOutput("rst s_regw", 32'(sIf.regw), 32'd0);
        checkOutput("rst s_adr", sIf.adr, 32'd0);
        checkOutput("rst s_wdata", sIf.wdata, 32'd0);
        checkOutput("rst m0_ack", 32'(m0If.ack), 32'd0);
        @(posedge clk);
        #1 rstz = 1'b1;
        slaveLat = 3;
        m0Acked = 0;
        m1AckCyc = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            slaveStep();
            #1;
            if (k == 1) checkOutput("rst firstGrant", 32'(grant), 32'd2);
            if (m0If.ack) m0Acked = 1;
            if (m1If.ack && m1AckCyc < 0) begin
                m1AckCyc = k;
                m1If.regr = 0;
                checkOutput("rst m1_rdat", m1If.rdat, 32'h76543210);
            end
        end
        clearMasters();
        checkOutput("rst m0NeverAcked", 32'(m0Acked), 32'd0);
        checkOutput("rst m1AckCycle", m1AckCyc, 4);
    endtask

    // Transaction-level model: arbiter free from idleFrom, each transfer ends at a
    // cycle fixed by slave latency or the timeout, followed by GAP_CYC idle cycles.
    task automatic randomRun(input int nCycles);
        int          g, ackCyc, idleFrom, owner, lastG, win, tLat;
        bit          tWrite, tErr, expStrobe, req0, req1;
        logic [31:0] tAdr, tWdata, tRdat, expRd;
        bit          active[2], dropped[2], ackSeen[2], typW[2], typR[2];
        int          waitC[2];
        logic [1:0]  t;
        doReset();
        spuriousEn = 1'b1;
        g = -1000; ackCyc = -1000; idleFrom = 0; owner = 0; lastG = 1;
        tWrite = 0; tAdr = '0; tWdata = '0; tRdat = '0; tLat = 3;
        for (int i = 0; i < 2; i++) begin
            active[i] = 0; dropped[i] = 0; ackSeen[i] = 0; typW[i] = 0; typR[i] = 0;
            waitC[i] = 0;
        end
        for (int k = 0; k < nCycles; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 2; i++) begin
                if (ackSeen[i]) begin
                    active[i] = 0;
                    ackSeen[i] = 0;
                    waitC[i] = $urandom_range(0, 3);
                end else if (!active[i]) begin
                    if (waitC[i] == 0) begin
                        active[i] = 1;
                        dropped[i] = 0;
                        t = 2'($urandom_range(1, 3));
                        typW[i] = t[0];
                        typR[i] = t[1];
                    end else begin
                        waitC[i]--;
                    end
                end else if (owner == i && k > g && k <= ackCyc && $urandom_range(0, 7) == 0) begin
                    dropped[i] = 1;
                end
            end
            m0If.regw = active[0] && !dropped[0] && typW[0];
            m0If.regr = active[0] && !dropped[0] && typR[0];
            m1If.regw = active[1] && !dropped[1] && typW[1];
            m1If.regr = active[1] && !dropped[1] && typR[1];
            m0If.adr = $urandom; m0If.wdata = $urandom;
            m1If.adr = $urandom; m1If.wdata = $urandom;
            slaveLat = tLat;
            slaveRdat = tRdat;
            slaveStep();
            #1;
            expStrobe = (k > g) && (k <= ackCyc);
            checkOutput("rnd s_regw", 32'(sIf.regw), 32'(expStrobe && tWrite));
            checkOutput("rnd s_regr", 32'(sIf.regr), 32'(expStrobe && !tWrite));
            if (expStrobe) begin
                checkOutput("rnd s_adr", sIf.adr, tAdr);
                checkOutput("rnd s_wdata", sIf.wdata, tWdata);
                checkOutput("rnd busyGrant", 32'(grant), (owner == 1) ? 32'd2 : 32'd1);
            end
            if (k >= idleFrom) checkOutput("rnd idleGrant", 32'(grant), 32'd0);
            tErr  = (tLat + 1 > TIMEOUT);
            expRd = tErr ? ERR_VAL : (tWrite ? 32'd0 : tRdat);
            checkOutput("rnd m0_ack", 32'(m0If.ack), 32'(k == ackCyc && owner == 0));
            checkOutput("rnd m1_ack", 32'(m1If.ack), 32'(k == ackCyc && owner == 1));
            checkOutput("rnd m0_rdat", m0If.rdat, (k == ackCyc && owner == 0) ? expRd : 32'd0);
            checkOutput("rnd m1_rdat", m1If.rdat, (k == ackCyc && owner == 1) ? expRd : 32'd0);
            checkOutput("rnd m0_err", 32'(m0If.err), 32'(k == ackCyc && owner == 0 && tErr));
            checkOutput("rnd m1_err", 32'(m1If.err), 32'(k == ackCyc && owner == 1 && tErr));
            ackSeen[0] = m0If.ack;
            ackSeen[1] = m1If.ack;
            if (k >= idleFrom) begin
                req0 = m0If.regw | m0If.regr;
                req1 = m1If.regw | m1If.regr;
                if (req0 || req1) begin
                    win = (req0 && req1) ? (1 - lastG) : (req1 ? 1 : 0);
                    lastG  = win;
                    owner  = win;
                    g      = k;
                    tWrite = win ? m1If.regw : m0If.regw;
                    tAdr   = win ? m1If.adr : m0If.adr;
                    tWdata = win ? m1If.wdata : m0If.wdata;
                    case ($urandom_range(0, 15))
                        0:       tLat = 100;
                        1:       tLat = TIMEOUT - 1;
                        default: tLat = $urandom_range(0, 5);
                    endcase
                    tRdat    = $urandom;
                    ackCyc   = (tLat + 1 <= TIMEOUT) ? g + 1 + tLat : g + TIMEOUT;
                    idleFrom = ackCyc + 1 + GAP_CYC;
                end
            end
        end
        clearMasters();
        spuriousEn = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{1,0,0,0,    3, 32'h00000000, 0, 1, 32'h00000000, 0, 4};
        vecs[1] = '{0,0,0,1,    3, 32'h12345678, 1, 0, 32'h12345678, 0, 4};
        vecs[2] = '{1,0,0,1,    3, 32'h11112222, 0, 1, 32'h00000000, 0, 4};
        vecs[3] = '{1,1,0,0,    3, 32'hAAAA5555, 0, 1, 32'h00000000, 0, 4};
        vecs[4] = '{0,0,0,1,    0, 32'h0000CAFE, 1, 0, 32'h0000CAFE, 0, 1};
        vecs[5] = '{0,1,0,0, 1000, 32'h01010101, 0, 0, ERR_VAL,      1, 64};
        vecs[6] = '{0,0,1,0, 1000, 32'h02020202, 1, 1, ERR_VAL,      1, 64};
        vecs[7] = '{0,1,0,0,   63, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 64};
        vecs[8] = '{0,0,0,1,   62, 32'h13579BDF, 1, 0, 32'h13579BDF, 0, 63};
        vecs[9] = '{0,1,1,0,    2, 32'h00C0FFEE, 0, 0, 32'h00C0FFEE, 0, 3};

        rstz = 1'b0;
        m0If.regw = 1; m0If.regr = 0; m0If.adr = ADR0; m0If.wdata = WD0;
        m1If.regw = 0; m1If.regr = 1; m1If.adr = ADR1; m1If.wdata = WD1;
        sIf.ack = 1; sIf.rdat = 32'hFFFFFFFF; sIf.err = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset grant", 32'(grant), 32'd0);
        checkOutput("reset s_regw", 32'(sIf.regw), 32'd0);
        checkOutput("reset s_regr", 32'(sIf.regr), 32'd0);
        checkOutput("reset s_adr", sIf.adr, 32'd0);
        checkOutput("reset s_wdata", sIf.wdata, 32'd0);
        checkOutput("reset m0_ack", 32'(m0If.ack), 32'd0);
        checkOutput("reset m0_err", 32'(m0If.err), 32'd0);
        checkOutput("reset m0_rdat", m0If.rdat, 32'd0);
        checkOutput("reset m1_ack", 32'(m1If.ack), 32'd0);
        checkOutput("reset m1_err", 32'(m1If.err), 32'd0);
        checkOutput("reset m1_rdat", m1If.rdat, 32'd0);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);
        roundRobinSeq();
        resetMidTransfer();
        randomRun(3000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
